scariv_lsu_ex0_arbiter: RTL and testbench

Shares the single EX0 entry of one LSU pipeline between two requesters: the LSU replay queue and the LSU issue unit. Each cycle it grants the older request by commit/group ID. A starvation counter stops either source from being locked out indefinitely. The winner is held in a one-entry output register with valid/ready back-pressure from the pipe. The block sits between the replay queue/issue unit and `scariv_lsu_pipe`, one instance per LSU pipe, and drops in-flight operations on pipeline flush.

---
 rtl/scariv_lsu_ex0_arbiter.sv | 160 ++++++++++++++++
 tb/tb_scariv_lsu_ex0_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/scariv_lsu_ex0_arbiter.sv
// EX0 entry arbiter for one LSU pipe: picks the older of the replay and issue requests,
// with a starvation override, and holds the winner in a one-entry output register.
module scariv_lsu_ex0_arbiter #(
  parameter int CMT_ID_W     = 6,
  parameter int GRP_W        = 4,
  parameter int PAYLOAD_W    = 128,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,

  input  logic                 i_rpl_valid,
  input  logic [CMT_ID_W-1:0]  i_rpl_cmt_id,
  input  logic [GRP_W-1:0]     i_rpl_grp_id,
  input  logic [PAYLOAD_W-1:0] i_rpl_payload,
  output logic                 o_rpl_ready,

  input  logic                 i_iss_valid,
  input  logic [CMT_ID_W-1:0]  i_iss_cmt_id,
  input  logic [GRP_W-1:0]     i_iss_grp_id,
  input  logic [PAYLOAD_W-1:0] i_iss_payload,
  output logic                 o_iss_ready,

  output logic                 o_ex0_valid,
  output logic                 o_ex0_src,
  output logic [CMT_ID_W-1:0]  o_ex0_cmt_id,
  output logic [GRP_W-1:0]     o_ex0_grp_id,
  output logic [PAYLOAD_W-1:0] o_ex0_payload,
  input  logic                 i_ex0_ready,

  input  logic                 i_flush_valid,
  input  logic [CMT_ID_W-1:0]  i_flush_cmt_id,
  input  logic [GRP_W-1:0]     i_flush_grp_id
);

  localparam logic [7:0] StarveLimit = 8'(STARVE_LIMIT);

  // True when (a_cmt, a_grp) is strictly older than (b_cmt, b_grp).
  // The cmt_id MSB is a wrap bit, so differing MSBs invert the index order.
  function automatic logic isOlder(
    input logic [CMT_ID_W-1:0] a_cmt,
    input logic [GRP_W-1:0]    a_grp,
    input logic [CMT_ID_W-1:0] b_cmt,
    input logic [GRP_W-1:0]    b_grp
  );
    logic res;
    if (a_cmt != b_cmt) begin
      if (a_cmt[CMT_ID_W-1] == b_cmt[CMT_ID_W-1]) begin
        res = (a_cmt[CMT_ID_W-2:0] < b_cmt[CMT_ID_W-2:0]);
      end else begin
        res = (a_cmt[CMT_ID_W-2:0] > b_cmt[CMT_ID_W-2:0]);
      end
    end else begin
      res = (a_grp < b_grp);
    end
    return res;
  endfunction

  logic                 ex0_valid_q,   ex0_valid_d;
  logic                 ex0_src_q,     ex0_src_d;
  logic [CMT_ID_W-1:0]  ex0_cmt_q,     ex0_cmt_d;
  logic [GRP_W-1:0]     ex0_grp_q,     ex0_grp_d;
  logic [PAYLOAD_W-1:0] ex0_payload_q, ex0_payload_d;
  logic [7:0]           starve_cnt_q,  starve_cnt_d;
  logic                 last_src_q,    last_src_d;
  logic                 active_q;

  logic can_load;
  logic arb_en;
  logic both_valid;
  logic rpl_older;
  logic starving;
  logic pick_rpl;
  logic grant_rpl;
  logic grant_iss;
  logic grant;
  logic flush_kill;

  // Arbitration: age order, unless the last winner has monopolised the slot for
  // STARVE_LIMIT consecutive contested grants. active_q keeps grants off while
  // reset is asserted without using the reset net as ordinary logic.
  always_comb begin
    can_load   = ~ex0_valid_q | i_ex0_ready;
    arb_en     = active_q & can_load & ~i_flush_valid;
    both_valid = i_rpl_valid & i_iss_valid;
    rpl_older  = isOlder(i_rpl_cmt_id, i_rpl_grp_id, i_iss_cmt_id, i_iss_grp_id);
    starving   = both_valid & (starve_cnt_q >= StarveLimit);
    pick_rpl   = 1'b0;
    if (both_valid) begin
      pick_rpl = starving ? ~last_src_q : rpl_older;
    end else begin
      pick_rpl = i_rpl_valid;
    end
    grant_rpl  = arb_en & i_rpl_valid & pick_rpl;
    grant_iss  = arb_en & i_iss_valid & ~pick_rpl;
    grant      = grant_rpl | grant_iss;
    // Entries equal to or younger than the flush point are dropped.
    flush_kill = i_flush_valid & ex0_valid_q &
                 ~isOlder(ex0_cmt_q, ex0_grp_q, i_flush_cmt_id, i_flush_grp_id);
  end

  assign o_rpl_ready = grant_rpl;
  assign o_iss_ready = grant_iss;

  // Output register and starvation tracking next-state.
  always_comb begin
    ex0_valid_d   = ex0_valid_q;
    ex0_src_d     = ex0_src_q;
    ex0_cmt_d     = ex0_cmt_q;
    ex0_grp_d     = ex0_grp_q;
    ex0_payload_d = ex0_payload_q;
    starve_cnt_d  = starve_cnt_q;
    last_src_d    = last_src_q;

    if (grant) begin
      ex0_valid_d   = 1'b1;
      ex0_src_d     = grant_rpl;
      ex0_cmt_d     = grant_rpl ? i_rpl_cmt_id  : i_iss_cmt_id;
      ex0_grp_d     = grant_rpl ? i_rpl_grp_id  : i_iss_grp_id;
      ex0_payload_d = grant_rpl ? i_rpl_payload : i_iss_payload;
      last_src_d    = grant_rpl;
      if (both_valid && (grant_rpl == last_src_q)) begin
        starve_cnt_d = (starve_cnt_q >= StarveLimit) ? StarveLimit : starve_cnt_q + 8'd1;
      end else begin
        starve_cnt_d = 8'd1;
      end
    end else if (i_ex0_ready || flush_kill) begin
      ex0_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      active_q      <= 1'b0;
      ex0_valid_q   <= 1'b0;
      ex0_src_q     <= 1'b0;
      ex0_cmt_q     <= '0;
      ex0_grp_q     <= '0;
      ex0_payload_q <= '0;
      starve_cnt_q  <= 8'd0;
      last_src_q    <= 1'b0;
    end else begin
      active_q      <= 1'b1;
      ex0_valid_q   <= ex0_valid_d;
      ex0_src_q     <= ex0_src_d;
      ex0_cmt_q     <= ex0_cmt_d;
      ex0_grp_q     <= ex0_grp_d;
      ex0_payload_q <= ex0_payload_d;
      starve_cnt_q  <= starve_cnt_d;
      last_src_q    <= last_src_d;
    end
  end

  assign o_ex0_valid   = ex0_valid_q;
  assign o_ex0_src     = ex0_src_q;
  assign o_ex0_cmt_id  = ex0_cmt_q;
  assign o_ex0_grp_id  = ex0_grp_q;
  assign o_ex0_payload = ex0_payload_q;

endmodule

// File: tb/tb_scariv_lsu_ex0_arbiter.sv
// Directed bench for scariv_lsu_ex0_arbiter: age order, wrap, starvation, flush,
// back-pressure and asynchronous reset, with hand-computed expectations.
module tb_scariv_lsu_ex0_arbiter;

  logic         clk;
  logic         rstN;
  logic         rplValid, issValid, ex0Ready, flushValid;
  logic [5:0]   rplCmt, issCmt, flushCmt;
  logic [3:0]   rplGrp, issGrp, flushGrp;
  logic [127:0] rplPayload, issPayload;
  logic         rplReady, issReady, ex0Valid, ex0Src;
  logic [5:0]   ex0Cmt;
  logic [3:0]   ex0Grp;
  logic [127:0] ex0Payload;

  int errors = 0;
  int checks = 0;

  scariv_lsu_ex0_arbiter #(
    .CMT_ID_W(6), .GRP_W(4), .PAYLOAD_W(128), .STARVE_LIMIT(8)
  ) dut (
    .i_clk(clk), .i_reset_n(rstN),
    .i_rpl_valid(rplValid), .i_rpl_cmt_id(rplCmt), .i_rpl_grp_id(rplGrp),
    .i_rpl_payload(rplPayload), .o_rpl_ready(rplReady),
    .i_iss_valid(issValid), .i_iss_cmt_id(issCmt), .i_iss_grp_id(issGrp),
    .i_iss_payload(issPayload), .o_iss_ready(issReady),
    .o_ex0_valid(ex0Valid), .o_ex0_src(ex0Src), .o_ex0_cmt_id(ex0Cmt),
    .o_ex0_grp_id(ex0Grp), .o_ex0_payload(ex0Payload), .i_ex0_ready(ex0Ready),
    .i_flush_valid(flushValid), .i_flush_cmt_id(flushCmt), .i_flush_grp_id(flushGrp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [5:0] rc, input logic [3:0] rg,
                               input logic iv, input logic [5:0] ic, input logic [3:0] ig,
                               input logic rdy, input logic fv, input logic [5:0] fc,
                               input logic [3:0] fg);
    rplValid   = rv;
    rplCmt     = rc;
    rplGrp     = rg;
    rplPayload = {8'hA5, 120'(rc)};
    issValid   = iv;
    issCmt     = ic;
    issGrp     = ig;
    issPayload = {8'h3C, 120'(ic)};
    ex0Ready   = rdy;
    flushValid = fv;
    flushCmt   = fc;
    flushGrp   = fg;
    #1;
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    applyStimulus(1, 6'd1, 4'b0001, 1, 6'd2, 4'b0001, 1, 0, 6'd0, 4'd0);
    checkOutput("reset_valid", ex0Valid, 1'b0);
    checkOutput("reset_readys", {rplReady, issReady}, 2'b00);
    applyStimulus(0, 6'd0, 4'd0, 0, 6'd0, 4'd0, 1, 0, 6'd0, 4'd0);
    @(negedge clk);
    rstN = 1'b1;
    stepClk();
  endtask

  initial begin
    rstN = 1'b0;
    #12;
    doReset();
    checkOutput("reset_src", ex0Src, 1'b0);
    checkOutput("reset_cmt", ex0Cmt, 6'd0);
    checkOutput("reset_payload", ex0Payload, 128'd0);

    // Replay only
    applyStimulus(1, 6'd5, 4'b0001, 0, 6'd0, 4'd0, 1, 0, 6'd0, 4'd0);
    checkOutput("t1_readys", {rplReady, issReady}, 2'b10);
    stepClk();
    checkOutput("t1_valid", ex0Valid, 1'b1);
    checkOutput("t1_src", ex0Src, 1'b1);
    checkOutput("t1_cmt", ex0Cmt, 6'd5);
    checkOutput("t1_grp", ex0Grp, 4'b0001);
    checkOutput("t1_payload", ex0Payload, {8'hA5, 120'd5});
    applyStimulus(0, 6'd0, 4'd0, 0, 6'd0, 4'd0, 1, 0, 6'd0, 4'd0);
    stepClk();
    checkOutput("t1_drain", ex0Valid, 1'b0);

    // Age order, including wrap
    applyStimulus(1, 6'd9, 4'b0001, 1, 6'd7, 4'b0001, 1, 0, 6'd0, 4'd0);
    checkOutput("t2_age_readys", {rplReady, issReady}, 2'b01);
    stepClk();
    checkOutput("t2_age_src", ex0Src, 1'b0);
    checkOutput("t2_age_cmt", ex0Cmt, 6'd7);
    applyStimulus(1, 6'b100001, 4'b0001, 1, 6'b011110, 4'b0001, 1, 0, 6'd0, 4'd0);
    checkOutput("t2_wrap_readys", {rplReady, issReady}, 2'b01);
    stepClk();
    checkOutput("t2_wrap_cmt", ex0Cmt, 6'd30);
    checkOutput("t2_wrap_payload", ex0Payload, {8'h3C, 120'd30});

    // Same cmt: group bit decides
    applyStimulus(1, 6'd4, 4'b0100, 1, 6'd4, 4'b0010, 1, 0, 6'd0, 4'd0);
    checkOutput("t3_grp_readys", {rplReady, issReady}, 2'b01);
    stepClk();
    checkOutput("t3_grp", ex0Grp, 4'b0010);
    applyStimulus(1, 6'd4, 4'b0001, 1, 6'd4, 4'b0100, 1, 0, 6'd0, 4'd0);
    checkOutput("t3_grp_rev_readys", {rplReady, issReady}, 2'b10);
    stepClk();
    checkOutput("t3_grp_rev_src", ex0Src, 1'b1);

    // Starvation: issue always older; replay wins grants 9 and 18
    doReset();
    applyStimulus(1, 6'd10, 4'b0001, 1, 6'd2, 4'b0001, 1, 0, 6'd0, 4'd0);
    for (int k = 1; k <= 18; k++) begin
      checkOutput($sformatf("t4_grant%0d", k), {rplReady, issReady},
                  (k == 9 || k == 18) ? 2'b10 : 2'b01);
      stepClk();
    end
    checkOutput("t4_last_src", ex0Src, 1'b1);

    // Flush of a held entry
    applyStimulus(1, 6'd6, 4'b0010, 0, 6'd0, 4'd0, 1, 0, 6'd0, 4'd0);
    stepClk();
    checkOutput("t5_loaded", ex0Valid, 1'b1);
    applyStimulus(1, 6'd8, 4'b0001, 1, 6'd9, 4'b0001, 0, 1, 6'd6, 4'b0001);
    checkOutput("t5_flush_readys", {rplReady, issReady}, 2'b00);
    stepClk();
    checkOutput("t5_flush_clears", ex0Valid, 1'b0);
    applyStimulus(1, 6'd6, 4'b0010, 0, 6'd0, 4'd0, 1, 0, 6'd0, 4'd0);
    stepClk();
    applyStimulus(0, 6'd0, 4'd0, 0, 6'd0, 4'd0, 0, 1, 6'd6, 4'b0100);
    stepClk();
    checkOutput("t5_older_kept", ex0Valid, 1'b1);
    checkOutput("t5_older_cmt", ex0Cmt, 6'd6);
    applyStimulus(1, 6'd8, 4'b0001, 1, 6'd9, 4'b0001, 1, 1, 6'd6, 4'b0001);
    checkOutput("t5_flush_rdy_readys", {rplReady, issReady}, 2'b00);
    stepClk();
    checkOutput("t5_flush_rdy_clears", ex0Valid, 1'b0);

    // Back-pressure hold, then asynchronous reset mid-hold
    applyStimulus(0, 6'd0, 4'd0, 1, 6'd3, 4'b0001, 1, 0, 6'd0, 4'd0);
    stepClk();
    applyStimulus(1, 6'd20, 4'b0001, 1, 6'd21, 4'b0001, 0, 0, 6'd0, 4'd0);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("t6_hold_readys%0d", k), {rplReady, issReady}, 2'b00);
      checkOutput($sformatf("t6_hold_cmt%0d", k), {ex0Valid, ex0Cmt}, {1'b1, 6'd3});
      stepClk();
    end
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("t6_async_valid", ex0Valid, 1'b0);
    checkOutput("t6_async_readys", {rplReady, issReady}, 2'b00);
    rstN = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
